// File: rtl/prbs_frame_ctrl.sv
// prbs_frame_ctrl
// Sequences the external 19-bit PRBS LFSR for the FSK transmit path: seeds it,
// presents one bit per programmable bit period to the modulator over a
// valid/ready handshake, advances it on every accepted bit, and counts bits
// per frame (or runs continuously when the frame length is zero).
//
// Ports
//   clk_i          single clock, rising edge
//   rst_i          synchronous active-high reset
//   start_i        begin a frame (sampled only in IDLE)
//   abort_i        terminate the current frame immediately
//   baud_div_i     extra cycles per bit, latched on an accepted start
//   frame_len_i    bits per frame (0 = continuous), latched on an accepted start
//   prbs_data_i    LFSR state, bit 0 is the transmitted bit
//   lfsr_reset_o   reseeds the LFSR
//   lfsr_enable_o  advances the LFSR one step
//   bit_out_o      current bit to the modulator (0 when not valid)
//   bit_valid_o    bit_out_o is valid
//   bit_ready_i    modulator accepts the bit
//   busy_o         high whenever the controller is not idle
//   done_o         one-cycle pulse on normal frame completion
//   bit_count_o    bits accepted in the current or most recent frame
module prbs_frame_ctrl #(
    parameter int DIV_W = 16,
    parameter int LEN_W = 20
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [DIV_W-1:0] baud_div_i,
    input  logic [LEN_W-1:0] frame_len_i,
    input  logic [18:0]      prbs_data_i,
    output logic             lfsr_reset_o,
    output logic             lfsr_enable_o,
    output logic             bit_out_o,
    output logic             bit_valid_o,
    input  logic             bit_ready_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [LEN_W-1:0] bit_count_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEED,
        S_PRESENT,
        S_WAIT,
        S_FINISH
    } state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   count_q, count_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [DIV_W-1:0]   baud_q, baud_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               bit_valid_q;
    logic               busy_q;
    logic               done_q;

    // Only the LSB of the LFSR state is transmitted.
    logic unused_prbs;
    assign unused_prbs = ^prbs_data_i[18:1];

    // Next-state logic. Abort outside IDLE overrides everything, so the bit
    // count never advances on a cycle that also aborts.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        div_d   = div_q;
        baud_d  = baud_q;
        len_d   = len_q;
        if (abort_i && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        baud_d  = baud_div_i;
                        len_d   = frame_len_i;
                        state_d = S_SEED;
                    end
                end
                S_SEED: begin
                    count_d = '0;
                    state_d = S_PRESENT;
                end
                S_PRESENT: begin
                    if (bit_ready_i) begin
                        // Count wraps naturally in continuous mode.
                        count_d = count_q + 1'b1;
                        if ((len_q != '0) && (count_d == len_q)) begin
                            state_d = S_FINISH;
                        end else begin
                            div_d   = baud_q;
                            state_d = S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    // Counting down from baud_q to 0 gives baud_q+1 WAIT cycles.
                    if (div_q == '0) begin
                        state_d = S_PRESENT;
                    end else begin
                        div_d = div_q - 1'b1;
                    end
                end
                S_FINISH: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and registered status outputs, decoded from the next state so
    // they line up with the state they describe.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            div_q       <= '0;
            baud_q      <= '0;
            len_q       <= '0;
            bit_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            div_q       <= div_d;
            baud_q      <= baud_d;
            len_q       <= len_d;
            bit_valid_q <= (state_d == S_PRESENT);
            busy_q      <= (state_d != S_IDLE);
            done_q      <= (state_d == S_FINISH);
        end
    end

    assign lfsr_reset_o  = rst_i | (state_q == S_SEED);
    assign lfsr_enable_o = (state_q == S_PRESENT) & bit_ready_i & ~abort_i & ~rst_i;
    // The bit follows the LFSR directly; it holds while stalled because the
    // LFSR only advances on a handshake.
    assign bit_out_o     = bit_valid_q & prbs_data_i[0];
    assign bit_valid_o   = bit_valid_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign bit_count_o   = count_q;

endmodule

// File: tb/tb_prbs_frame_ctrl.sv
// Testbench for prbs_frame_ctrl. Models the external 19-bit LFSR, drives
// frames and compares handshakes against a scoreboard of expected
// (cycle, bit) pairs. A second instance with a 4-bit counter covers wrap.
module tb_prbs_frame_ctrl;

    typedef struct {
        int   cyc;
        logic bitVal;
    } hsExp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;
    int          compared = 0;
    int          mismatched = 0;
    int          doneCntA = 0;
    hsExp_t      expQ[$];

    // Instance A: default widths
    logic        startA = 1'b0;
    logic        abortA = 1'b0;
    logic [15:0] baudA = '0;
    logic [19:0] lenA = '0;
    logic [18:0] lfsrA = '0;
    logic        lfsrRstA, lfsrEnA, bitOutA, bitValidA, busyA, doneA;
    logic        readyA = 1'b1;
    logic [19:0] countA;

    // Instance B: 4-bit frame length / counter
    logic        startB = 1'b0;
    logic        abortB = 1'b0;
    logic [15:0] baudB = '0;
    logic [3:0]  lenB = '0;
    logic [18:0] lfsrB = '0;
    logic        lfsrRstB, lfsrEnB, bitOutB, bitValidB, busyB, doneB;
    logic        readyB = 1'b1;
    logic [3:0]  countB;

    prbs_frame_ctrl #(.DIV_W(16), .LEN_W(20)) dutA (
        .clk_i(clk), .rst_i(rst), .start_i(startA), .abort_i(abortA),
        .baud_div_i(baudA), .frame_len_i(lenA), .prbs_data_i(lfsrA),
        .lfsr_reset_o(lfsrRstA), .lfsr_enable_o(lfsrEnA), .bit_out_o(bitOutA),
        .bit_valid_o(bitValidA), .bit_ready_i(readyA), .busy_o(busyA),
        .done_o(doneA), .bit_count_o(countA)
    );

    prbs_frame_ctrl #(.DIV_W(16), .LEN_W(4)) dutB (
        .clk_i(clk), .rst_i(rst), .start_i(startB), .abort_i(abortB),
        .baud_div_i(baudB), .frame_len_i(lenB), .prbs_data_i(lfsrB),
        .lfsr_reset_o(lfsrRstB), .lfsr_enable_o(lfsrEnB), .bit_out_o(bitOutB),
        .bit_valid_o(bitValidB), .bit_ready_i(readyB), .busy_o(busyB),
        .done_o(doneB), .bit_count_o(countB)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // External LFSR: right shift, feedback into bit 18, seed 19'b1.
    always @(posedge clk) begin
        if (lfsrRstA)     lfsrA <= 19'd1;
        else if (lfsrEnA) lfsrA <= {lfsrA[0] ^ lfsrA[1] ^ lfsrA[2] ^ lfsrA[5], lfsrA[18:1]};
        if (lfsrRstB)     lfsrB <= 19'd1;
        else if (lfsrEnB) lfsrB <= {lfsrB[0] ^ lfsrB[1] ^ lfsrB[2] ^ lfsrB[5], lfsrB[18:1]};
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0d, expected %0d (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    // Handshake monitor: every accepted bit must match the head of the scoreboard.
    always @(negedge clk) begin
        if (doneA) doneCntA++;
        if (!rst && bitValidA && readyA && !abortA) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_handshake", cyc, -1);
            end else begin
                hsExp_t e;
                e = expQ.pop_front();
                checkOutput("hs_cycle", cyc, e.cyc);
                checkOutput("hs_bit", int'(bitOutA), int'(e.bitVal));
                checkOutput("hs_lfsr_en", int'(lfsrEnA), 1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tickUntil(input int target);
        while (cyc < target) tick();
    endtask

    // Pulses START on instance A for one cycle; c0 is the cycle START is high.
    task automatic applyStimulus(input logic [15:0] baud, input logic [19:0] len, output int c0);
        baudA  = baud;
        lenA   = len;
        startA = 1'b1;
        c0     = cyc;
        tick();
        startA = 1'b0;
    endtask

    // Expected bits after a seed: a single 1 followed by zeros.
    task automatic pushBits(input int firstCyc, input int n, input int period);
        for (int k = 0; k < n; k++) begin
            hsExp_t e;
            e.cyc    = firstCyc + k * period;
            e.bitVal = (k == 0);
            expQ.push_back(e);
        end
    endtask

    task automatic waitIdle(input int budget);
        int n;
        n = 0;
        while (busyA && n < budget) begin
            tick();
            n++;
        end
        checkOutput("idle_within_budget", int'(n < budget), 1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int c0;
        int doneBefore;

        // Reset state
        tick();
        tick();
        checkOutput("rst_busy", int'(busyA), 0);
        checkOutput("rst_valid", int'(bitValidA), 0);
        checkOutput("rst_bit_out", int'(bitOutA), 0);
        checkOutput("rst_done", int'(doneA), 0);
        checkOutput("rst_count", int'(countA), 0);
        checkOutput("rst_lfsr_reset", int'(lfsrRstA), 1);
        checkOutput("rst_lfsr_en", int'(lfsrEnA), 0);
        rst = 1'b0;
        tick();

        // Basic frame
        $display("[TB] basic frame");
        doneBefore = doneCntA;
        readyA = 1'b1;
        pushBits(cyc + 2, 4, 5);
        applyStimulus(16'd3, 20'd4, c0);
        checkOutput("basic_seed_lfsr_reset", int'(lfsrRstA), 1);
        checkOutput("basic_seed_busy", int'(busyA), 1);
        tickUntil(c0 + 17);
        checkOutput("basic_done_early", int'(doneA), 0);
        tick();
        checkOutput("basic_done", int'(doneA), 1);
        checkOutput("basic_busy_at_done", int'(busyA), 1);
        tick();
        checkOutput("basic_busy_after", int'(busyA), 0);
        checkOutput("basic_done_after", int'(doneA), 0);
        checkOutput("basic_count", int'(countA), 4);
        checkOutput("basic_done_pulses", doneCntA - doneBefore, 1);
        checkOutput("basic_queue_empty", expQ.size(), 0);

        // Backpressure
        $display("[TB] backpressure");
        readyA = 1'b0;
        expQ.push_back('{cyc + 6, 1'b1});
        pushBits(cyc + 11, 3, 5);
        expQ[1].bitVal = 1'b0;
        applyStimulus(16'd3, 20'd4, c0);
        tickUntil(c0 + 2);
        for (int k = 2; k <= 5; k++) begin
            checkOutput("bp_valid", int'(bitValidA), 1);
            checkOutput("bp_bit_out", int'(bitOutA), 1);
            checkOutput("bp_lfsr_en", int'(lfsrEnA), 0);
            tick();
        end
        readyA = 1'b1;
        #1;
        checkOutput("bp_lfsr_en_hs", int'(lfsrEnA), 1);
        waitIdle(100);
        checkOutput("bp_count", int'(countA), 4);
        checkOutput("bp_queue_empty", expQ.size(), 0);

        // Continuous mode with abort on the 10th handshake
        $display("[TB] continuous and abort");
        doneBefore = doneCntA;
        pushBits(cyc + 2, 9, 2);
        applyStimulus(16'd0, 20'd0, c0);
        tickUntil(c0 + 20);
        abortA = 1'b1;
        #1;
        checkOutput("abort_valid", int'(bitValidA), 1);
        checkOutput("abort_lfsr_en", int'(lfsrEnA), 0);
        tick();
        abortA = 1'b0;
        checkOutput("abort_busy", int'(busyA), 0);
        checkOutput("abort_count", int'(countA), 9);
        checkOutput("abort_done", int'(doneA), 0);
        tick();
        checkOutput("abort_no_done", doneCntA - doneBefore, 0);
        checkOutput("abort_queue_empty", expQ.size(), 0);

        // START and config changes mid-frame are ignored
        $display("[TB] ignored start and config");
        doneBefore = doneCntA;
        pushBits(cyc + 2, 4, 5);
        applyStimulus(16'd3, 20'd4, c0);
        tickUntil(c0 + 4);
        startA = 1'b1;
        baudA  = 16'd7;
        tick();
        startA = 1'b0;
        checkOutput("ign_no_reseed", int'(lfsrRstA), 0);
        tickUntil(c0 + 18);
        checkOutput("ign_done", int'(doneA), 1);
        waitIdle(100);
        checkOutput("ign_count", int'(countA), 4);
        checkOutput("ign_done_pulses", doneCntA - doneBefore, 1);
        checkOutput("ign_queue_empty", expQ.size(), 0);

        // Reset mid-frame, then a full 19-bit frame from a fresh seed
        $display("[TB] reset mid-frame");
        expQ.push_back('{cyc + 2, 1'b1});
        applyStimulus(16'd3, 20'd4, c0);
        tickUntil(c0 + 3);
        rst = 1'b1;
        #1;
        checkOutput("mrst_lfsr_reset", int'(lfsrRstA), 1);
        tick();
        rst = 1'b0;
        #1;
        checkOutput("mrst_busy", int'(busyA), 0);
        checkOutput("mrst_valid", int'(bitValidA), 0);
        checkOutput("mrst_bit_out", int'(bitOutA), 0);
        checkOutput("mrst_lfsr_en", int'(lfsrEnA), 0);
        checkOutput("mrst_done", int'(doneA), 0);
        checkOutput("mrst_count", int'(countA), 0);
        checkOutput("mrst_queue_empty", expQ.size(), 0);
        tick();
        pushBits(cyc + 2, 19, 2);
        applyStimulus(16'd0, 20'd19, c0);
        waitIdle(100);
        checkOutput("seq_count", int'(countA), 19);
        checkOutput("seq_queue_empty", expQ.size(), 0);

        // Counter wrap on the 4-bit instance
        $display("[TB] wrap");
        baudB  = 16'd0;
        lenB   = 4'd0;
        startB = 1'b1;
        c0     = cyc;
        tick();
        startB = 1'b0;
        tickUntil(c0 + 31);
        checkOutput("wrap_count_15", int'(countB), 15);
        tickUntil(c0 + 33);
        checkOutput("wrap_count_0", int'(countB), 0);
        checkOutput("wrap_busy", int'(busyB), 1);
        tickUntil(c0 + 35);
        checkOutput("wrap_count_1", int'(countB), 1);
        checkOutput("wrap_no_done", int'(doneB), 0);
        abortB = 1'b1;
        tick();
        abortB = 1'b0;
        checkOutput("wrap_abort_idle", int'(busyB), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
